// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline: Tuse/Tnew RAW hazard detection,
// mult/div occupancy tracking and a saturating stall-cycle performance counter.
module pipe_hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int MD_W     = 4,
  parameter int SC_W     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [1:0]      id_rs_tuse,
  input  logic [1:0]      id_rt_tuse,
  input  logic            id_md_op,
  input  logic [4:0]      ex_wa,
  input  logic [1:0]      ex_tnew,
  input  logic [4:0]      mem_wa,
  input  logic [1:0]      mem_tnew,
  input  logic            ex_md_start,
  input  logic            ex_md_div,
  input  logic            flush_req,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            ifid_clr,
  output logic            idex_clr,
  output logic            exmem_clr,
  output logic            memwb_clr,
  output logic            md_busy,
  output logic [SC_W-1:0] stall_cnt
);

  localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_CYC - 1);
  localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYC - 1);
  localparam logic [1:0]      TUSE_NONE = 2'd3;

  logic [MD_W-1:0] r_md_cnt;
  logic [SC_W-1:0] r_stall_cnt;

  logic w_haz_rs;
  logic w_haz_rt;
  logic w_md_busy;
  logic w_md_stall;
  logic w_stall;

  // A source operand hazards when the producer's result is not forwardable
  // by the time the consumer needs it; EX and MEM producers are checked independently.
  function automatic logic raw_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    logic ex_hit;
    logic mem_hit;
    ex_hit  = (src == e_wa) && (e_tnew > tuse);
    mem_hit = (src == m_wa) && (m_tnew > tuse);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (ex_hit || mem_hit);
  endfunction

  always_comb begin
    w_haz_rs   = raw_hazard(id_rs, id_rs_tuse, ex_wa, ex_tnew, mem_wa, mem_tnew);
    w_haz_rt   = raw_hazard(id_rt, id_rt_tuse, ex_wa, ex_tnew, mem_wa, mem_tnew);
    w_md_busy  = ex_md_start | (r_md_cnt != '0);
    w_md_stall = id_md_op & w_md_busy;
    w_stall    = (w_haz_rs | w_haz_rt | w_md_stall) & ~flush_req;
  end

  // Output priority: reset, then flush, then stall, else idle.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    md_busy   = w_md_busy;
    if (reset) begin
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      memwb_clr = 1'b1;
      md_busy   = 1'b0;
    end else if (flush_req) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (w_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_clr = 1'b1;
    end
  end

  // A new start restarts the count even while a previous operation is in flight.
  always_ff @(posedge clk) begin
    if (reset || flush_req) begin
      r_md_cnt <= '0;
    end else if (ex_md_start) begin
      r_md_cnt <= ex_md_div ? DIV_LOAD : MULT_LOAD;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with a 4-bit stall
// counter shares the stimulus to exercise saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_wa, mem_wa;
  logic [1:0] id_rs_tuse, id_rt_tuse, ex_tnew, mem_tnew;
  logic       id_md_op, ex_md_start, ex_md_div, flush_req;

  logic        pc_en, ifid_en, ifid_clr, idex_clr, exmem_clr, memwb_clr, md_busy;
  logic [31:0] stall_cnt;
  logic        s_pc_en, s_ifid_en, s_ifid_clr, s_idex_clr, s_exmem_clr, s_memwb_clr, s_md_busy;
  logic [3:0]  s_stall_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_sc  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse), .id_md_op(id_md_op),
    .ex_wa(ex_wa), .ex_tnew(ex_tnew), .mem_wa(mem_wa), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div), .flush_req(flush_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .memwb_clr(memwb_clr), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.SC_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse), .id_md_op(id_md_op),
    .ex_wa(ex_wa), .ex_tnew(ex_tnew), .mem_wa(mem_wa), .mem_tnew(mem_tnew),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div), .flush_req(flush_req),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_clr(s_ifid_clr), .idex_clr(s_idex_clr),
    .exmem_clr(s_exmem_clr), .memwb_clr(s_memwb_clr), .md_busy(s_md_busy),
    .stall_cnt(s_stall_cnt)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_rs_tuse = 2'd3; id_rt_tuse = 2'd3; id_md_op = 0;
    ex_wa = 0; ex_tnew = 0; mem_wa = 0; mem_tnew = 0;
    ex_md_start = 0; ex_md_div = 0; flush_req = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // ctrl = {pc_en, ifid_en, ifid_clr, idex_clr, exmem_clr, memwb_clr}
  task automatic chk_ctrl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_en, ifid_en, ifid_clr, idex_clr, exmem_clr, memwb_clr}, {26'd0, exp});
  endtask

  task automatic chk_cnt(input string tag);
    int sat;
    sat = (exp_sc > 15) ? 15 : exp_sc;
    chk({tag, "_cnt"},   stall_cnt, exp_sc);
    chk({tag, "_cnt4"},  {28'd0, s_stall_cnt}, sat);
  endtask

  localparam logic [5:0] C_RESET = 6'b001111;
  localparam logic [5:0] C_IDLE  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_FLUSH = 6'b111110;

  initial begin
    // ---- 1: reset ----
    idle_inputs();
    reset = 1;
    #1;
    chk_ctrl("rst_ctrl0", C_RESET);
    tick();
    ex_md_start = 1;
    #1;
    chk_ctrl("rst_ctrl1", C_RESET);
    chk("rst_busy", md_busy, 0);
    tick();
    reset = 0; ex_md_start = 0;
    #1;
    chk_ctrl("post_rst_ctrl", C_IDLE);
    chk("post_rst_busy", md_busy, 0);
    chk_cnt("post_rst");

    // ---- 2: load-use on rs via EX ----
    ex_wa = 5; ex_tnew = 2; id_rs = 5; id_rs_tuse = 1;
    #1;
    chk_ctrl("lu_stall", C_STALL);
    tick(); exp_sc++;
    chk_cnt("lu");
    ex_tnew = 1;
    #1;
    chk_ctrl("lu_release", C_IDLE);
    tick();
    chk_cnt("lu_hold");

    // rt hazard via MEM, then tnew not exceeding tuse
    idle_inputs();
    mem_wa = 7; mem_tnew = 1; id_rt = 7; id_rt_tuse = 0;
    #1;
    chk_ctrl("rt_mem_stall", C_STALL);
    tick(); exp_sc++;
    id_rt_tuse = 1;
    #1;
    chk_ctrl("rt_mem_equal", C_IDLE);
    tick();
    chk_cnt("rt_mem");

    // ---- 3: register zero and unused operand ----
    idle_inputs();
    id_rs = 0; ex_wa = 0; ex_tnew = 3; id_rs_tuse = 0;
    #1;
    chk_ctrl("zero_reg", C_IDLE);
    id_rs = 5; ex_wa = 5; id_rs_tuse = 3;
    #1;
    chk_ctrl("tuse_unused", C_IDLE);
    // EX match is harmless, MEM match still hazards
    id_rs_tuse = 1; ex_tnew = 0; mem_wa = 5; mem_tnew = 2;
    #1;
    chk_ctrl("mem_indep", C_STALL);
    tick(); exp_sc++;
    chk_cnt("haz_misc");

    // ---- 4: div occupancy ----
    idle_inputs();
    ex_md_start = 1; ex_md_div = 1;
    #1;
    chk("div_c0_busy", md_busy, 1);
    chk_ctrl("div_c0_ctrl", C_IDLE);
    tick();
    ex_md_start = 0; ex_md_div = 0; id_md_op = 1;
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk($sformatf("div_c%0d_busy", c), md_busy, 1);
      chk_ctrl($sformatf("div_c%0d_ctrl", c), C_STALL);
      tick(); exp_sc++;
    end
    #1;
    chk("div_c10_busy", md_busy, 0);
    chk_ctrl("div_c10_ctrl", C_IDLE);
    chk_cnt("div");

    // mult occupancy
    id_md_op = 0; ex_md_start = 1; ex_md_div = 0;
    #1;
    chk("mul_c0_busy", md_busy, 1);
    tick();
    ex_md_start = 0; id_md_op = 1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk_ctrl($sformatf("mul_c%0d_ctrl", c), C_STALL);
      tick(); exp_sc++;
    end
    #1;
    chk("mul_c5_busy", md_busy, 0);
    chk_ctrl("mul_c5_ctrl", C_IDLE);
    chk_cnt("mul");

    // ---- 5: flush dominates hazard and md stall ----
    idle_inputs();
    ex_md_start = 1; ex_md_div = 1;
    tick();                       // md_cnt = 9
    ex_md_start = 0; ex_md_div = 0;
    tick();                       // md_cnt = 8
    tick();                       // md_cnt = 7
    ex_wa = 5; ex_tnew = 2; id_rs = 5; id_rs_tuse = 1; id_md_op = 1; flush_req = 1;
    #1;
    chk_ctrl("flush_ctrl", C_FLUSH);
    chk("flush_busy", md_busy, 1);
    tick();
    idle_inputs();
    #1;
    chk("flush_md_cleared", md_busy, 0);
    chk_cnt("flush");

    // ---- 6: saturation on the 4-bit counter ----
    reset = 1;
    tick();
    reset = 0; exp_sc = 0;
    #1;
    chk_cnt("sat_start");
    ex_wa = 9; ex_tnew = 3; id_rt = 9; id_rt_tuse = 2;
    for (int c = 1; c <= 20; c++) begin
      tick(); exp_sc++;
      chk_cnt($sformatf("sat_%0d", c));
    end
    reset = 1;
    #1;
    chk_ctrl("sat_rst_ctrl", C_RESET);
    tick();
    exp_sc = 0;
    chk_cnt("sat_rst");
    reset = 0;
    tick(); exp_sc++;
    chk_cnt("sat_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
